ks_wide_add_seq: RTL and testbench

- Multi-cycle sequencer that performs a WORDS×8-bit add/subtract using one shared 8-bit kogge_stone_carry instance.
- Processes one byte slice per cycle, LSB first, and registers the inter-slice carry between cycles.
- Uses a valid/ready handshake on both the operand side and the result side.
- Sits between the ALU opcode decoder and the register write-back, so ALU widths above 8 bits reuse one 8-bit prefix network instead of a wider tree.

---
 rtl/ks_wide_add_seq.sv | 184 ++++++++++++++++++
 tb/tb_ks_wide_add_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_wide_add_seq.sv
// Multi-cycle WORDS x 8-bit add/subtract that reuses one 8-bit Kogge-Stone carry network,
// one byte slice per cycle, LSB first. Optional zero flag under KS_WIDE_ADD_ZERO_FLAG_EN.

// 8-bit parallel-prefix carry network. Each output is the carry out of its bit.
// The carry-in is folded into g[0] before this block sees it.
module kogge_stone_carry (
  input  logic [7:0] g,
  input  logic [7:0] p,
  output logic [7:0] c
);
  logic [7:0] g1;
  logic [7:2] p1;
  logic [7:0] g2;
  logic [7:4] p2;
  // p[0] cannot affect any carry: bit 0 has no lower group to propagate from.
  logic unused_p0;

  assign unused_p0 = p[0];

  // Distance-1 combine.
  always_comb begin
    g1    = g;
    p1    = p[7:2] & p[6:1];
    for (int i = 1; i < 8; i++) begin
      g1[i] = g[i] | (p[i] & g[i-1]);
    end
  end

  // Distance-2 combine.
  always_comb begin
    g2 = g1;
    p2 = p1[7:4] & p1[5:2];
    for (int i = 2; i < 8; i++) begin
      g2[i] = g1[i] | (p1[i] & g1[i-2]);
    end
  end

  // Distance-4 combine produces the final group generates.
  always_comb begin
    c = g2;
    for (int i = 4; i < 8; i++) begin
      c[i] = g2[i] | (p2[i] & g2[i-4]);
    end
  end
endmodule

module ks_wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*WORDS-1:0] op_a,
  input  logic [8*WORDS-1:0] op_b,
  input  logic               op_sub,
  input  logic               op_cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*WORDS-1:0] sum,
  output logic               cout,
  output logic               ovf
`ifdef KS_WIDE_ADD_ZERO_FLAG_EN
  ,
  output logic               zf
`endif
);
  localparam int W  = 8 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and DONE holds its outputs until the transfer.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            carry;
  logic [IW-1:0]   idx;
  logic            accept;
  logic            last;

  logic [7:0]      sa;
  logic [7:0]      sb;
  logic [7:0]      sg;
  logic [7:0]      sp;
  logic [7:0]      c_vec;
  logic [7:0]      sum_byte;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs; in_ready stays low for the whole reset cycle.
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  assign accept = in_valid && in_ready;
  assign last   = (idx == LAST);

  // Current slice operands and the shared prefix network.
  assign sa = a_reg[idx*8 +: 8];
  assign sb = b_reg[idx*8 +: 8];
  assign sg = sa & sb;
  assign sp = sa ^ sb;

  kogge_stone_carry u_carry (
    .g ({sg[7:1], sg[0] | (sp[0] & carry)}),
    .p (sp),
    .c (c_vec)
  );

  assign sum_byte = sp ^ {c_vec[6:0], carry};

`ifdef KS_WIDE_ADD_ZERO_FLAG_EN
  logic [7:0] zacc;
`endif

  // Operand latch and slice datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
`ifdef KS_WIDE_ADD_ZERO_FLAG_EN
      zacc  <= '0;
      zf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= op_a;
            b_reg <= op_b ^ {W{op_sub}};
            carry <= op_sub ? 1'b1 : op_cin;
            idx   <= '0;
`ifdef KS_WIDE_ADD_ZERO_FLAG_EN
            zacc  <= '0;
            zf    <= 1'b0;
`endif
          end
        end
        RUN: begin
          sum[idx*8 +: 8] <= sum_byte;
          carry           <= c_vec[7];
`ifdef KS_WIDE_ADD_ZERO_FLAG_EN
          zacc            <= zacc | sum_byte;
`endif
          if (last) begin
            cout <= c_vec[7];
            ovf  <= c_vec[7] ^ c_vec[6];
`ifdef KS_WIDE_ADD_ZERO_FLAG_EN
            zf   <= ~|(zacc | sum_byte);
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ks_wide_add_seq.sv
// Bench for ks_wide_add_seq: directed table, hold/reset sequences, and random ops
// checked against an arithmetic reference model.
module tb_ks_wide_add_seq;
  localparam int WORDS = 4;
  localparam int W     = 8 * WORDS;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_sub;
  logic         op_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
`ifdef KS_WIDE_ADD_ZERO_FLAG_EN
  logic         zf;
`endif

  int n_vec;
  int n_bad;

  ks_wide_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .op_cin    (op_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
`ifdef KS_WIDE_ADD_ZERO_FLAG_EN
    ,
    .zf        (zf)
`endif
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         z;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: modulo-2^W arithmetic with an extra carry bit; overflow from operand/result signs.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic sub, input logic cin,
                                output logic [W-1:0] s, output logic co, output logic ov);
    logic [W-1:0] bx;
    logic [W:0]   t;
    bx = sub ? ~b : b;
    t  = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    s  = t[W-1:0];
    co = t[W];
    ov = (a[W-1] == bx[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  // Driver: one full operation including latency, hold stability and result handshake.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin,
                        input logic [W-1:0] es, input logic eco, input logic eov, input logic ez,
                        input int hold, input string tag);
    int  cyc;
    bit  seen;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!in_ready) begin
      chk({tag, " in_ready wait"}, {{(W-1){1'b0}}, in_ready}, 1);
      return;
    end
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    op_sub   = sub;
    op_cin   = cin;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, " out_valid after accept"}, {{(W-1){1'b0}}, out_valid}, 0);
    seen = 0;
    for (cyc = 1; cyc <= 64; cyc++) begin
      in_valid = 1'($urandom_range(0, 1));
      op_a     = $urandom;
      op_b     = $urandom;
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        break;
      end
    end
    chk({tag, " latency"}, W'(cyc), W'(WORDS));
    if (!seen) begin
      in_valid = 1'b0;
      return;
    end
    chk({tag, " sum"}, sum, es);
    chk({tag, " cout"}, {{(W-1){1'b0}}, cout}, {{(W-1){1'b0}}, eco});
    chk({tag, " ovf"}, {{(W-1){1'b0}}, ovf}, {{(W-1){1'b0}}, eov});
`ifdef KS_WIDE_ADD_ZERO_FLAG_EN
    chk({tag, " zf"}, {{(W-1){1'b0}}, zf}, {{(W-1){1'b0}}, ez});
`else
    if (ez === 1'bx) $display("note: %s zero expectation unknown", tag);
`endif
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom_range(0, 1));
      op_a     = $urandom;
      @(negedge clk);
      chk({tag, " hold sum"}, sum, es);
      chk({tag, " hold cout/ovf/valid"}, {{(W-3){1'b0}}, cout, ovf, out_valid},
          {{(W-3){1'b0}}, eco, eov, 1'b1});
      chk({tag, " hold in_ready"}, {{(W-1){1'b0}}, in_ready}, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " out_valid after handshake"}, {{(W-1){1'b0}}, out_valid}, 0);
    chk({tag, " in_ready in idle"}, {{(W-1){1'b0}}, in_ready}, 1);
  endtask

  initial begin
    logic [W-1:0] es;
    logic         eco;
    logic         eov;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    logic         rc;

    n_vec = 0;
    n_bad = 0;
    tbl[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{32'h00000007, 32'h00000005, 1'b1, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h2345678A, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_sub    = 1'b0;
    op_cin    = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset in_ready", {{(W-1){1'b0}}, in_ready}, 0);
    chk("reset out_valid", {{(W-1){1'b0}}, out_valid}, 0);
    chk("reset sum", sum, 0);
    chk("reset cout/ovf", {{(W-2){1'b0}}, cout, ovf}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset in_ready", {{(W-1){1'b0}}, in_ready}, 1);

    // Directed table; the first entry also holds the result for 5 cycles.
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin,
             tbl[i].s, tbl[i].co, tbl[i].ov, tbl[i].z,
             (i == 0) ? 5 : 0, $sformatf("tbl%0d", i));
    end

    // Reset while the slice index is 2: partial result must be discarded.
    in_valid = 1'b1;
    op_a     = 32'h01010101;
    op_b     = 32'h01010101;
    op_sub   = 1'b0;
    op_cin   = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst out_valid", {{(W-1){1'b0}}, out_valid}, 0);
    chk("midrst sum", sum, 0);
    chk("midrst cout/ovf", {{(W-2){1'b0}}, cout, ovf}, 0);
    chk("midrst in_ready during reset", {{(W-1){1'b0}}, in_ready}, 0);
    rst = 1'b0;
    #1;
    chk("midrst in_ready after release", {{(W-1){1'b0}}, in_ready}, 1);
    @(negedge clk);
    run_op(32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0, 0, "rst_recover");

    // Random operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: rb = ~ra + 1'b1;
        1: ra = 32'h7FFFFFFF;
        default: ;
      endcase
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      model(ra, rb, rs, rc, es, eco, eov);
      run_op(ra, rb, rs, rc, es, eco, eov, (es == '0), $urandom_range(0, 3),
             $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
